// File: rtl/block_merger.sv
// Reassembles SHA-256 padded blocks into one buffer, validates separator, zero fill and
// length field, then presents the recovered message left-aligned with its bit length.
`timescale 1ns / 1ps
module block_merger #(
   parameter int unsigned BLOCK_W    = 512,
   parameter int unsigned MAX_BLOCKS = 2,
   parameter int unsigned LEN_W      = 11
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            blk_valid,
   output logic                            blk_ready,
   input  logic [BLOCK_W-1:0]              blk_data,
   input  logic                            blk_last,
   output logic                            msg_valid,
   input  logic                            msg_ready,
   output logic [BLOCK_W*MAX_BLOCKS-1:0]   msg_data,
   output logic [LEN_W-1:0]                msg_len,
   output logic [2:0]                      msg_err
);

   localparam int unsigned TotW = BLOCK_W * MAX_BLOCKS;
   localparam int unsigned CntW = $clog2(MAX_BLOCKS + 1);
   localparam int unsigned FldW = 64;
   localparam int unsigned ArW  = FldW + 2;

   typedef enum logic [1:0] {StCollect, StCheck, StOutput} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [CntW-1:0]   k_q, k_d;
   logic              ovf_q, ovf_d;
   logic [TotW-1:0]   buf_q, buf_d;
   logic              msg_valid_q, msg_valid_d;
   logic [TotW-1:0]   msg_data_q, msg_data_d;
   logic [LEN_W-1:0]  msg_len_q, msg_len_d;
   logic [2:0]        msg_err_q, msg_err_d;

   int unsigned       fld_lo;
   int unsigned       sep_idx;
   logic [FldW-1:0]   fld;
   logic [ArW-1:0]    f_w, n_w;
   logic              bad_len, bad_pad;
   logic [TotW-1:0]   one_v, pad_mask, keep_mask;
   logic [2:0]        err_c;

   assign blk_ready = rst_n && (state_q == StCollect);
   assign msg_valid = msg_valid_q;
   assign msg_data  = msg_data_q;
   assign msg_len   = msg_len_q;
   assign msg_err   = msg_err_q;

   // Length field sits in the low 64 bits of block k-1; everything derived from it here.
   always_comb begin
      one_v   = TotW'(1);
      fld_lo  = BLOCK_W * (MAX_BLOCKS - 32'(k_q));
      fld     = FldW'(buf_q >> fld_lo);
      f_w     = ArW'(fld);
      n_w     = ArW'(BLOCK_W) * ArW'(k_q);
      bad_len = (|fld[FldW-1:LEN_W]) || (f_w + ArW'(65) > n_w)
                || (f_w + ArW'(65 + BLOCK_W) <= n_w);
      sep_idx   = TotW - 1 - 32'(fld[LEN_W-1:0]);
      pad_mask  = ((one_v << sep_idx) - one_v) & ~((one_v << (fld_lo + FldW)) - one_v);
      bad_pad   = !bad_len && (((buf_q & (one_v << sep_idx)) == '0)
                               || ((buf_q & pad_mask) != '0));
      keep_mask = ~((one_v << (TotW - 32'(fld[LEN_W-1:0]))) - one_v);
      err_c     = {bad_pad, bad_len, ovf_q};
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      k_d         = k_q;
      ovf_d       = ovf_q;
      buf_d       = buf_q;
      msg_valid_d = msg_valid_q;
      msg_data_d  = msg_data_q;
      msg_len_d   = msg_len_q;
      msg_err_d   = msg_err_q;
      unique case (state_q)
         StCollect: begin
            if (blk_valid && blk_ready) begin
               if (cnt_q >= CntW'(MAX_BLOCKS)) begin
                  ovf_d = 1'b1;
               end else begin
                  for (int unsigned i = 0; i < MAX_BLOCKS; i++) begin
                     if (cnt_q == CntW'(i)) buf_d[TotW-1-BLOCK_W*i -: BLOCK_W] = blk_data;
                  end
               end
               // Saturating: only "count >= MAX_BLOCKS" matters beyond the limit.
               if (cnt_q < CntW'(MAX_BLOCKS)) cnt_d = cnt_q + CntW'(1);
               if (blk_last) begin
                  state_d = StCheck;
                  k_d     = (cnt_q >= CntW'(MAX_BLOCKS)) ? CntW'(MAX_BLOCKS)
                                                         : cnt_q + CntW'(1);
               end
            end
         end
         StCheck: begin
            msg_len_d   = fld[LEN_W-1:0];
            msg_err_d   = err_c;
            msg_data_d  = (err_c == 3'b000) ? (buf_q & keep_mask) : buf_q;
            msg_valid_d = 1'b1;
            state_d     = StOutput;
         end
         StOutput: begin
            if (msg_ready) begin
               msg_valid_d = 1'b0;
               cnt_d       = '0;
               ovf_d       = 1'b0;
               buf_d       = '0;
               state_d     = StCollect;
            end
         end
         default: state_d = StCollect;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StCollect;
         cnt_q       <= '0;
         k_q         <= '0;
         ovf_q       <= 1'b0;
         buf_q       <= '0;
         msg_valid_q <= 1'b0;
         msg_data_q  <= '0;
         msg_len_q   <= '0;
         msg_err_q   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         k_q         <= k_d;
         ovf_q       <= ovf_d;
         buf_q       <= buf_d;
         msg_valid_q <= msg_valid_d;
         msg_data_q  <= msg_data_d;
         msg_len_q   <= msg_len_d;
         msg_err_q   <= msg_err_d;
      end
   end

endmodule

// File: tb/tb_block_merger.sv
// Directed and randomized bench for block_merger; expectations come from a bit-level
// padding model that decodes the delivered blocks straight from the padding rules.
`timescale 1ns / 1ps
module tb_block_merger;

   localparam int BW = 512;
   localparam int MB = 2;
   localparam int LW = 11;
   localparam int TW = BW * MB;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          blk_valid = 1'b0;
   logic          blk_ready;
   logic [BW-1:0] blk_data = '0;
   logic          blk_last = 1'b0;
   logic          msg_valid;
   logic          msg_ready = 1'b0;
   logic [TW-1:0] msg_data;
   logic [LW-1:0] msg_len;
   logic [2:0]    msg_err;

   block_merger #(.BLOCK_W(BW), .MAX_BLOCKS(MB), .LEN_W(LW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .blk_valid (blk_valid),
      .blk_ready (blk_ready),
      .blk_data  (blk_data),
      .blk_last  (blk_last),
      .msg_valid (msg_valid),
      .msg_ready (msg_ready),
      .msg_data  (msg_data),
      .msg_len   (msg_len),
      .msg_err   (msg_err)
   );

   always #5 clk = ~clk;

   int            compared = 0;
   int            mismatched = 0;
   logic [BW-1:0] blks [4];
   int            nblk;
   logic [TW-1:0] e_data;
   logic [LW-1:0] e_len;
   logic [2:0]    e_err;

   task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] want);
      compared++;
      assert (got === want) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, want);
      end
   endtask

   task automatic chk1(input string tag, input logic got, input logic want);
      compared++;
      assert (got === want) else begin
         mismatched++;
         $error("FAIL %s: observed %b expected %b", tag, got, want);
      end
   endtask

   function automatic logic [BW-1:0] rand_blk();
      logic [BW-1:0] r;
      for (int w = 0; w < BW / 32; w++) r[w*32 +: 32] = $urandom;
      return r;
   endfunction

   // Correctly padded message of L random bits spread over k blocks.
   task automatic build(input int L, input int k);
      logic [TW-1:0] t;
      int            n;
      n = BW * k;
      t = {rand_blk(), rand_blk()};
      for (int p = L; p < TW; p++) t[TW-1-p] = 1'b0;
      t[TW-1-L]    = 1'b1;
      t[TW-n +: 64] = 64'(L);
      for (int i = 0; i < k; i++) blks[i] = t[TW-1-BW*i -: BW];
      nblk = k;
   endtask

   task automatic model();
      logic [TW-1:0] b;
      logic [63:0]   f;
      logic [65:0]   fw, nw;
      int            k, n, L;
      logic          bl, bp;
      b = '0;
      L = 0;
      for (int i = 0; i < nblk && i < MB; i++) b[TW-1-BW*i -: BW] = blks[i];
      k  = (nblk > MB) ? MB : nblk;
      n  = BW * k;
      f  = blks[k-1][63:0];
      fw = {2'b00, f};
      nw = 66'(n);
      bl = ((f >> LW) != 64'd0) || (fw + 66'd65 > nw) || (fw + 66'd65 + 66'd512 <= nw);
      bp = 1'b0;
      if (!bl) begin
         L = int'(f);
         if (b[TW-1-L] !== 1'b1) bp = 1'b1;
         for (int p = L + 1; p <= n - 65; p++) if (b[TW-1-p]) bp = 1'b1;
      end
      e_err  = {bp, bl, (nblk > MB)};
      e_len  = f[LW-1:0];
      e_data = b;
      if (e_err == 3'b000) for (int p = L; p < TW; p++) e_data[TW-1-p] = 1'b0;
   endtask

   task automatic chk_out(input string tag);
      chk1({tag, "_valid"}, msg_valid, 1'b1);
      chk({tag, "_len"}, BW'(msg_len), BW'(e_len));
      chk({tag, "_err"}, BW'(msg_err), BW'(e_err));
      chk({tag, "_data_hi"}, msg_data[TW-1:BW], e_data[TW-1:BW]);
      chk({tag, "_data_lo"}, msg_data[BW-1:0], e_data[BW-1:0]);
   endtask

   // Sends blks[0..nblk-1], checks the CHECK cycle, output, hold period and handshake.
   task automatic run_msg(input int hold, input bit poke);
      model();
      msg_ready = 1'($urandom_range(0, 1));
      for (int i = 0; i < nblk; i++) begin
         int w = 0;
         blk_valid = 1'b1;
         blk_data  = blks[i];
         blk_last  = (i == nblk - 1);
         while (blk_ready !== 1'b1 && w < 20) begin
            @(posedge clk); #1;
            w++;
         end
         chk1("blk_ready_collect", blk_ready, 1'b1);
         @(posedge clk); #1;
      end
      blk_valid = 1'b0;
      blk_last  = 1'b0;
      blk_data  = '0;
      chk1("valid_in_check", msg_valid, 1'b0);
      chk1("ready_in_check", blk_ready, 1'b0);
      @(posedge clk); #1;
      chk_out("out");
      msg_ready = 1'b0;
      for (int h = 0; h < hold; h++) begin
         if (poke) begin
            blk_valid = 1'b1;
            blk_data  = rand_blk();
            blk_last  = 1'b1;
         end
         @(posedge clk); #1;
         chk_out("hold");
         chk1("ready_in_hold", blk_ready, 1'b0);
      end
      blk_valid = 1'b0;
      blk_last  = 1'b0;
      msg_ready = 1'b1;
      @(posedge clk); #1;
      msg_ready = 1'b0;
      chk1("valid_cleared", msg_valid, 1'b0);
      chk1("ready_after_hs", blk_ready, 1'b1);
   endtask

   task automatic chk_reset_state(input string tag);
      chk1({tag, "_blk_ready"}, blk_ready, 1'b0);
      chk1({tag, "_msg_valid"}, msg_valid, 1'b0);
      chk({tag, "_len"}, BW'(msg_len), '0);
      chk({tag, "_err"}, BW'(msg_err), '0);
      chk({tag, "_data_hi"}, msg_data[TW-1:BW], '0);
      chk({tag, "_data_lo"}, msg_data[BW-1:0], '0);
   endtask

   initial begin
      int L, k, mode, p;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_state("reset");
      rst_n = 1'b1;
      #1;
      chk1("ready_after_reset", blk_ready, 1'b1);

      // 640-bit header over two blocks, consumer always ready.
      build(640, 2);
      run_msg(0, 1'b0);
      chk("h640_err", BW'(msg_err), BW'(3'b000));
      // Single 256-bit block.
      build(256, 1);
      run_msg(0, 1'b0);
      // Empty message: separator at the very top bit.
      build(0, 1);
      run_msg(1, 1'b0);
      // Separator bit cleared.
      build(640, 2);
      blks[1][383] = 1'b0;
      run_msg(0, 1'b0);
      chk("sep_err", BW'(e_err), BW'(3'b100));
      // Non-minimal padding, then an oversized length field.
      build(256, 2);
      run_msg(0, 1'b0);
      chk("nonmin_err", BW'(e_err), BW'(3'b010));
      build(640, 2);
      blks[1][63:0] = 64'h1_0000_0000;
      run_msg(0, 1'b0);
      chk("biglen_err", BW'(e_err), BW'(3'b010));
      // Three blocks: third dropped, overflow flagged.
      build(640, 2);
      blks[2] = rand_blk();
      nblk = 3;
      run_msg(0, 1'b0);
      chk("ovf_err0", BW'(e_err[0]), BW'(1'b1));
      // Slow consumer with a source pushing a block it must not lose or take early.
      build(640, 2);
      run_msg(5, 1'b1);
      // Reset mid-collection, then a clean message.
      build(640, 2);
      blk_valid = 1'b1;
      blk_data  = blks[0];
      blk_last  = 1'b0;
      @(posedge clk); #1;
      blk_valid = 1'b0;
      rst_n     = 1'b0;
      @(posedge clk); #1;
      chk_reset_state("midreset");
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk1("ready_after_midreset", blk_ready, 1'b1);
      build(640, 2);
      run_msg(0, 1'b0);
      chk("clean_after_reset_err", BW'(e_err), BW'(3'b000));

      for (int it = 0; it < 40; it++) begin
         L = int'($urandom_range(0, 959));
         k = (L + 65 + 511) / 512;
         build(L, k);
         mode = int'($urandom_range(0, 4));
         case (mode)
            1: blks[L/BW][BW-1-(L%BW)] = ~blks[L/BW][BW-1-(L%BW)];
            2: if (k * BW - 65 > L) begin
                  p = int'($urandom_range(L + 1, k * BW - 65));
                  blks[p/BW][BW-1-(p%BW)] = 1'b1;
               end
            3: blks[k-1][63:0] = 64'($urandom_range(0, 2047));
            4: begin
                  blks[nblk] = rand_blk();
                  nblk++;
               end
            default: ;
         endcase
         run_msg(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
